display_scan_ctrl: RTL
======================

# display_scan_ctrl

Sequencer for the 8-digit seven-segment display path. Accepts a 32-bit hex/BCD value over a valid/ready handshake and double-buffers it so the display only changes at frame boundaries. Generates the refresh prescaler and digit scan, presenting one 4-bit digit plus its slot index per slot. `o_digit` feeds the BCD-to-seven-segment converter; `o_select` feeds the one-cold anode decoder; `o_blank` gates the anodes off.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot; must be ≥2.
- `N_DIGITS`, default 8: digits scanned; 1..8.
- `clock`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `i_value`, input, 32: value to display; nibble k goes to digit k; digit 0 is least significant.
- `i_valid`, input, 1: `i_value` is offered.
- `o_ready`, output, 1: pending buffer empty; transfer occurs when `i_valid & o_ready`.
- `i_enable`, input, 1: scan enable; low means display off.
- `o_digit`, output, 4: nibble for the current slot.
- `o_select`, output, 3: current slot index, 0..N_DIGITS-1.
- `o_blank`, output, 1: the current slot must be dark.
- `o_frame_done`, output, 1: one-cycle pulse at each frame wrap.

## Operation
- **Registers**
  - Prescaler `cnt`, 0..CLK_DIV-1.
  - `select`.
  - `shadow` (32 b): the value being displayed.
  - `pending` (32 b) plus `pend_full` flag.
  - FSM state.
- **FSM states:** S_OFF, S_SCAN.
  - S_OFF → S_SCAN when `i_enable`=1.
  - S_SCAN → S_OFF when `i_enable`=0.
  - Transitions take effect on the next edge.
- **S_OFF**
  - `cnt`=0, `select`=0, `o_blank`=1, `o_frame_done`=0.
  - `shadow` and `pending` are retained.
  - Handshake remains active.
- **S_SCAN**
  - `tick` = (`cnt`==CLK_DIV-1). `cnt` wraps to 0 on `tick`, otherwise increments.
  - On `tick`, `select` increments, wrapping N_DIGITS-1 → 0.
- **Frame boundary** is either the wrap edge or the S_OFF→S_SCAN entry edge. At a boundary, if `pend_full`: `shadow` ← `pending` and `pend_full` ← 0.
- **Handshake**
  - `o_ready` = !`pend_full`, a registered flag.
  - Transfer sets `pending` ← `i_value` and `pend_full` ← 1.
  - No bypass: a value accepted on a boundary edge is shown from the following boundary.
  - With `pend_full`=1, `i_valid` is ignored and the offered value must be held by the sender.
- **Outputs**
  - `o_digit` = nibble `select` of `shadow`, registered.
  - On a boundary edge, `o_digit` uses the newly loaded `shadow`.
- **Width rule:** nibbles ≥ N_DIGITS are never displayed. Their bits are still stored.

## Timing
- **Reset values**
  - State S_OFF, `cnt`=0, `select`=0.
  - `shadow`=0, `pending`=0, `pend_full`=0.
  - `o_ready`=1, `o_digit`=0, `o_select`=0, `o_blank`=1, `o_frame_done`=0.
- `o_select`, `o_digit` and `o_blank` change together on the `tick` edge and are stable for exactly CLK_DIV cycles.
- After entering S_SCAN, slot 0 lasts CLK_DIV cycles, counted from the entry edge.
- `o_frame_done` is high for the one cycle following the wrap edge. It is not asserted on the entry edge.
- `o_ready` falls the cycle after acceptance. It rises the cycle after the boundary that drains `pending`.
- **`i_enable` drop mid-frame:** next edge gives S_OFF, `select`=0 and blank.
- **Reset mid-operation:** all registers return immediately (asynchronously) to their reset values; any pending value is lost.

## Configuration
- **`DISP_LZB_EN` defined:** leading-zero blanking. In S_SCAN, `o_blank`=1 for slot i when i>0 and nibbles i..N_DIGITS-1 of `shadow` are all zero. Slot 0 is never blanked.
- **`DISP_LZB_EN` undefined:** `o_blank`=0 throughout S_SCAN.
- Either way, `o_blank`=1 in S_OFF.

## Structure
- **Package `disp_pkg`:**
  - State enum `disp_state_t` {S_OFF, S_SCAN}.
  - `DIGIT_W`=4.
  - `SEL_W`=3.
  - `VALUE_W`=32.
- **Sub-module `tick_gen`** (prescaler): parameter `CLK_DIV`; inputs `clock`, `reset`, `i_clear`; output `o_tick`.
- FSM, buffers and output registers live in the top module.

## Test plan
Bench configuration: CLK_DIV=4, N_DIGITS=8.

1. **Reset and enable.** Assert reset, then release with `i_enable`=1. Expect reset values throughout; then `o_select` steps 0..7 every 4 cycles; `o_frame_done` pulses once per 32 cycles.
2. **Frame-aligned load.** Send `i_value`=32'h1234_5678 mid-frame. Expect `o_ready`=0 next cycle; digits remain the old value until the wrap. From the wrap, slot 0 shows 8, slot 1 shows 7 … slot 7 shows 1; `o_ready` returns to 1.
3. **Back-pressure.** Make two back-to-back offers within one frame. Expect the first accepted; the second held (`o_ready`=0) until the boundary, then accepted; the second value is displayed one frame after the first.
4. **Leading-zero blanking (`DISP_LZB_EN`).** Load 32'h0000_0A05. Expect slots 0–2 lit showing 5, 0, A; slots 3–7 `o_blank`=1. Load 0. Expect only slot 0 lit, showing 0.
5. **Enable drop mid-frame.** Drop `i_enable` at slot 5, then re-enable. Expect next cycle `o_blank`=1 and `o_select`=0; on re-enable, scanning restarts at slot 0 and any pending value is loaded on entry.
6. **Reset mid-operation.** Assert reset while `pend_full`=1. Expect immediate return to reset values; after release `o_ready`=1 and `shadow`=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and widths for the seven-segment scan path.
//   disp_state_t : scan FSM state (S_OFF / S_SCAN)
//   DIGIT_W      : bits per displayed digit
//   SEL_W        : width of the slot index
//   VALUE_W      : width of the buffered display value
package disp_pkg;
  localparam int DIGIT_W = 4;
  localparam int SEL_W   = 3;
  localparam int VALUE_W = 32;

  typedef enum logic {
    S_OFF  = 1'b0,
    S_SCAN = 1'b1
  } disp_state_t;
endpackage

// File: rtl/tick_gen.sv
// Refresh prescaler: counts 0..CLK_DIV-1 and flags the last cycle of a slot.
//   clock   : system clock
//   reset   : async active-low reset
//   i_clear : hold the count at 0 (display off / leaving scan)
//   o_tick  : high while the count is CLK_DIV-1
module tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_clear || o_tick) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan sequencer with a frame-aligned double buffer.
//   clock, reset   : system clock, async active-low reset
//   i_value/i_valid/o_ready : value handshake into the pending buffer
//   i_enable       : scan enable (low = display off)
//   o_digit        : nibble for the current slot
//   o_select       : current slot index
//   o_blank        : current slot dark
//   o_frame_done   : one-cycle pulse after each frame wrap
// Build option: DISP_LZB_EN enables leading-zero blanking.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_DIV  = 100000,
  parameter int N_DIGITS = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_enable,
  output logic [DIGIT_W-1:0] o_digit,
  output logic [SEL_W-1:0]   o_select,
  output logic               o_blank,
  output logic               o_frame_done
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_DIGITS - 1);

  disp_state_t        state_q, state_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic [VALUE_W-1:0] shadow_q, shadow_d, pending_q, pending_d;
  logic               pend_full_q, pend_full_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               blank_q, blank_d, frame_q;
  logic               tick, clear, scanning, entry, wrap, boundary, accept;

  // Clear covers both the off state and the edge that leaves scan, so the
  // prescaler restarts at 0 and slot 0 lasts a full CLK_DIV from entry.
  assign clear = (state_q == S_OFF) || !i_enable;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .i_clear(clear),
    .o_tick (tick)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_OFF;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   if (i_enable)  state_d = S_SCAN;
      S_SCAN:  if (!i_enable) state_d = S_OFF;
      default: state_d = S_OFF;
    endcase
  end

  // Outputs / datapath next values
  always_comb begin
    scanning = (state_q == S_SCAN) && i_enable;
    entry    = (state_q == S_OFF) && i_enable;
    wrap     = scanning && tick && (select_q == LAST_SEL);
    boundary = wrap || entry;
    accept   = i_valid && !pend_full_q;

    select_d = '0;
    if (scanning) select_d = tick ? (wrap ? '0 : select_q + SEL_W'(1)) : select_q;

    shadow_d    = (boundary && pend_full_q) ? pending_q : shadow_q;
    pending_d   = accept ? i_value : pending_q;
    pend_full_d = pend_full_q;
    if (accept)                        pend_full_d = 1'b1;
    else if (boundary && pend_full_q)  pend_full_d = 1'b0;

    // Digit follows the post-edge select/shadow so a new frame shows new data.
    digit_d = shadow_d[int'(select_d)*DIGIT_W +: DIGIT_W];
    blank_d = (state_d == S_OFF);
  end

`ifdef DISP_LZB_EN
  logic lit;
  // A slot is lit if it or any more-significant displayed nibble is non-zero.
  always_comb begin
    lit = 1'b0;
    for (int k = 0; k < 8; k++)
      if (k < N_DIGITS && k >= int'(select_d) && shadow_d[k*DIGIT_W +: DIGIT_W] != '0)
        lit = 1'b1;
  end
  wire blank_nxt = blank_d || (select_d != '0 && !lit);
`else
  wire blank_nxt = blank_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      select_q    <= '0;
      shadow_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      digit_q     <= '0;
      blank_q     <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      select_q    <= select_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      digit_q     <= digit_d;
      blank_q     <= blank_nxt;
      frame_q     <= wrap;
    end
  end

  assign o_ready      = !pend_full_q;
  assign o_digit      = digit_q;
  assign o_select     = select_q;
  assign o_blank      = blank_q;
  assign o_frame_done = frame_q;
endmodule
